avf_sq_sampler: RTL and testbench

Sampling controller for store-queue (SQ) residency measurement in the AVF cross-layer monitor. It picks one SQ allocation per sampling period and tracks that entry from allocation through execute to retire. It emits one duration record per sample over a valid/ready handshake and keeps running sums for the stats collector. It owns the coarse timestamp that all SQ duration measurement uses.

---
 rtl/avf_sq_sampler_if.sv | 31 +++
 rtl/avf_sq_sampler.sv | 175 +++++++++++++++++
 tb/tb_avf_sq_sampler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/avf_sq_sampler_if.sv
// Event and record bundle between the SQ pipeline and the residency sampler.
interface avf_sq_sampler_if #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned DUR_W = 10
);
  logic             alloc_valid;
  logic [IDX_W-1:0] alloc_idx;
  logic             exec_valid;
  logic [IDX_W-1:0] exec_idx;
  logic             retire_valid;
  logic [IDX_W-1:0] retire_idx;
  logic             flush;
  logic             rec_valid;
  logic             rec_ready;
  logic [IDX_W-1:0] rec_idx;
  logic [DUR_W-1:0] rec_dur_exec;
  logic [DUR_W-1:0] rec_dur_end;
  logic             rec_timeout;

  modport master (
    output alloc_valid, alloc_idx, exec_valid, exec_idx, retire_valid, retire_idx,
           flush, rec_ready,
    input  rec_valid, rec_idx, rec_dur_exec, rec_dur_end, rec_timeout
  );

  modport slave (
    input  alloc_valid, alloc_idx, exec_valid, exec_idx, retire_valid, retire_idx,
           flush, rec_ready,
    output rec_valid, rec_idx, rec_dur_exec, rec_dur_end, rec_timeout
  );
endinterface

// File: rtl/avf_sq_sampler.sv
// Samples one SQ allocation per period and reports its alloc->exec/retire residency.
// Optional timeout exit when AVF_SQ_TIMEOUT_EN is defined.
module avf_sq_sampler #(
  parameter int unsigned DUR_W      = 10,
  parameter int unsigned PRESCALE_W = 4,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned PERIOD_W   = 8,
  parameter int unsigned ACC_W      = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  avf_sq_sampler_if.slave     sq,
  output logic [DUR_W-1:0]    timestamp,
  output logic [ACC_W-1:0]    acc_exec,
  output logic [ACC_W-1:0]    acc_end,
  output logic [ACC_W-1:0]    acc_count,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, WAIT_TRIG, WAIT_ALLOC, TRACK, REPORT} state_t;

  state_t                state;
  logic [PRESCALE_W-1:0] pre;
  logic [PERIOD_W-1:0]   cnt;
  logic [IDX_W-1:0]      cap_idx;
  logic [DUR_W-1:0]      start;
  logic [DUR_W-1:0]      dur_exec;
  logic                  exec_seen;
  logic                  rec_valid_q;
  logic [IDX_W-1:0]      rec_idx_q;
  logic [DUR_W-1:0]      rec_dur_exec_q;
  logic [DUR_W-1:0]      rec_dur_end_q;

  logic [PERIOD_W-1:0] period_ld;
  logic [DUR_W-1:0]    elapsed;
  logic                exec_hit;
  logic                retire_hit;

  assign period_ld  = (period == '0) ? PERIOD_W'(1) : period;
  assign elapsed    = timestamp - start;
  assign exec_hit   = sq.exec_valid && (sq.exec_idx == cap_idx) && !exec_seen;
  assign retire_hit = sq.retire_valid && (sq.retire_idx == cap_idx);

  assign sq.rec_valid    = rec_valid_q;
  assign sq.rec_idx      = rec_idx_q;
  assign sq.rec_dur_exec = rec_dur_exec_q;
  assign sq.rec_dur_end  = rec_dur_end_q;

`ifdef AVF_SQ_TIMEOUT_EN
  logic rec_timeout_q;
  assign sq.rec_timeout = rec_timeout_q;
`else
  assign sq.rec_timeout = 1'b0;
`endif

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  // Coarse timestamp shared by all SQ duration measurement
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre       <= '0;
      timestamp <= '0;
    end else begin
      pre <= pre + PRESCALE_W'(1);
      if (pre == '1) timestamp <= timestamp + DUR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      cnt            <= '0;
      cap_idx        <= '0;
      start          <= '0;
      dur_exec       <= '0;
      exec_seen      <= 1'b0;
      rec_valid_q    <= 1'b0;
      rec_idx_q      <= '0;
      rec_dur_exec_q <= '0;
      rec_dur_end_q  <= '0;
`ifdef AVF_SQ_TIMEOUT_EN
      rec_timeout_q  <= 1'b0;
`endif
      acc_exec       <= '0;
      acc_end        <= '0;
      acc_count      <= '0;
    end else begin
      case (state)
        IDLE: if (en) begin
          cnt   <= period_ld;
          state <= WAIT_TRIG;
          busy  <= 1'b1;
        end
        WAIT_TRIG: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == PERIOD_W'(1)) begin
            state <= WAIT_ALLOC;
          end else begin
            cnt <= cnt - PERIOD_W'(1);
          end
        end
        WAIT_ALLOC: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sq.alloc_valid) begin
            cap_idx   <= sq.alloc_idx;
            start     <= timestamp;
            exec_seen <= 1'b0;
            state     <= TRACK;
          end
        end
        TRACK: begin
          if (exec_hit) begin
            dur_exec  <= elapsed;
            exec_seen <= 1'b1;
          end
          // A matching retire takes priority over flush and timeout
          if (retire_hit) begin
            rec_valid_q    <= 1'b1;
            rec_idx_q      <= cap_idx;
            rec_dur_end_q  <= elapsed;
            rec_dur_exec_q <= exec_seen ? dur_exec : elapsed;
`ifdef AVF_SQ_TIMEOUT_EN
            rec_timeout_q  <= 1'b0;
`endif
            state          <= REPORT;
          end
`ifdef AVF_SQ_TIMEOUT_EN
          else if (elapsed == '1) begin
            rec_valid_q    <= 1'b1;
            rec_idx_q      <= cap_idx;
            rec_dur_end_q  <= '1;
            rec_dur_exec_q <= exec_seen ? dur_exec : '1;
            rec_timeout_q  <= 1'b1;
            state          <= REPORT;
          end
`endif
          else if (sq.flush) begin
            cnt   <= period_ld;
            state <= WAIT_TRIG;
          end
        end
        REPORT: if (sq.rec_ready) begin
          rec_valid_q <= 1'b0;
          acc_exec    <= sat_add(acc_exec, ACC_W'(rec_dur_exec_q));
          acc_end     <= sat_add(acc_end, ACC_W'(rec_dur_end_q));
          acc_count   <= sat_add(acc_count, ACC_W'(1));
          if (en) begin
            cnt   <= period_ld;
            state <= WAIT_TRIG;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avf_sq_sampler.sv
// Directed bench for avf_sq_sampler: record scoreboard, accumulator model, timestamp model.
module tb_avf_sq_sampler;

  typedef struct packed {
    logic [5:0] idx;
    logic [9:0] dexec;
    logic [9:0] dend;
    logic       tout;
  } rec_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] period;
  logic [9:0] timestamp;
  logic [23:0] acc_exec, acc_end, acc_count;
  logic       busy;

  avf_sq_sampler_if #(.IDX_W(6), .DUR_W(10)) sq ();

  avf_sq_sampler dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .period    (period),
    .sq        (sq),
    .timestamp (timestamp),
    .acc_exec  (acc_exec),
    .acc_end   (acc_end),
    .acc_count (acc_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; one tick per 16 cycles
  int e;
  always @(posedge clk) begin
    if (!reset) e <= 0;
    else        e <= e + 1;
  end

  function automatic logic [9:0] ts_model();
    return 10'(e >> 4);
  endfunction

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t exp_q[$];
  rec_t cur;
  int   m_exec = 0, m_end = 0, m_cnt = 0;
  logic [9:0] start_ts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wait_ts(input logic [9:0] v, input int budget);
    int n = 0;
    while (ts_model() != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ts", 32'(ts_model() == v), 32'd1);
  endtask

  task automatic alloc_pulse(input logic [5:0] idx);
    sq.alloc_valid = 1'b1; sq.alloc_idx = idx;
    @(negedge clk);
    sq.alloc_valid = 1'b0;
  endtask

  task automatic exec_pulse(input logic [5:0] idx);
    sq.exec_valid = 1'b1; sq.exec_idx = idx;
    @(negedge clk);
    sq.exec_valid = 1'b0;
  endtask

  task automatic retire_pulse(input logic [5:0] idx);
    sq.retire_valid = 1'b1; sq.retire_idx = idx;
    @(negedge clk);
    sq.retire_valid = 1'b0;
  endtask

  task automatic get_record(input string tag, input int budget);
    int n = 0;
    while (!sq.rec_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(sq.rec_valid), 32'd1);
    chk({tag, "_queued"}, 32'(exp_q.size() != 0), 32'd1);
    if (sq.rec_valid && exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk({tag, "_idx"},  32'(sq.rec_idx),      32'(cur.idx));
      chk({tag, "_exec"}, 32'(sq.rec_dur_exec), 32'(cur.dexec));
      chk({tag, "_end"},  32'(sq.rec_dur_end),  32'(cur.dend));
      chk({tag, "_tout"}, 32'(sq.rec_timeout),  32'(cur.tout));
    end
  endtask

  task automatic model_accept();
    m_exec += int'(cur.dexec);
    m_end  += int'(cur.dend);
    m_cnt  += 1;
  endtask

  task automatic chk_acc(input string tag);
    chk({tag, "_acc_exec"},  32'(acc_exec),  32'(m_exec));
    chk({tag, "_acc_end"},   32'(acc_end),   32'(m_end));
    chk({tag, "_acc_count"}, 32'(acc_count), 32'(m_cnt));
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; period = 8'd4;
    sq.alloc_valid = 1'b0;  sq.alloc_idx = '0;
    sq.exec_valid = 1'b0;   sq.exec_idx = '0;
    sq.retire_valid = 1'b0; sq.retire_idx = '0;
    sq.flush = 1'b0;        sq.rec_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ts", 32'(timestamp), 32'd0);
    chk("rst_valid", 32'(sq.rec_valid), 32'd0);
    chk("rst_idx", 32'(sq.rec_idx), 32'd0);
    chk("rst_exec", 32'(sq.rec_dur_exec), 32'd0);
    chk("rst_end", 32'(sq.rec_dur_end), 32'd0);
    chk("rst_tout", 32'(sq.rec_timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_acc("rst");

    // Basic sample with decoy events
    reset = 1'b1; en = 1'b1; period = 8'd4;
    @(negedge clk);
    chk("basic_busy", 32'(busy), 32'd1);
    wait_ts(10'd2, 200);
    chk("ts_2", 32'(timestamp), 32'(ts_model()));
    alloc_pulse(6'd5);
    wait_ts(10'd5, 200); exec_pulse(6'd6);
    wait_ts(10'd7, 200); exec_pulse(6'd5);
    wait_ts(10'd9, 200); exec_pulse(6'd5); retire_pulse(6'd4);
    chk("basic_no_early_rec", 32'(sq.rec_valid), 32'd0);
    wait_ts(10'd12, 200);
    exp_q.push_back('{idx: 6'd5, dexec: 10'd5, dend: 10'd10, tout: 1'b0});
    retire_pulse(6'd5);
    get_record("basic", 0);
    chk("basic_acc_before_hs", 32'(acc_count), 32'd0);
    model_accept();
    @(negedge clk);
    chk("basic_valid_drop", 32'(sq.rec_valid), 32'd0);
    chk("basic_busy_after", 32'(busy), 32'd1);
    chk_acc("basic");

    // Backpressure: record held, accumulators frozen
    sq.rec_ready = 1'b0;
    wait_ts(10'd14, 200); alloc_pulse(6'd33);
    wait_ts(10'd16, 200);
    exp_q.push_back('{idx: 6'd33, dexec: 10'd2, dend: 10'd2, tout: 1'b0});
    retire_pulse(6'd33);
    get_record("bp", 0);
    sq.alloc_valid = 1'b1; sq.alloc_idx = 6'd7;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(sq.rec_valid), 32'd1);
      chk("bp_hold_idx", 32'(sq.rec_idx), 32'd33);
      chk("bp_hold_end", 32'(sq.rec_dur_end), 32'd2);
      chk("bp_hold_count", 32'(acc_count), 32'd1);
    end
    sq.alloc_valid = 1'b0;
    sq.rec_ready = 1'b1;
    model_accept();
    @(negedge clk);
    chk("bp_valid_drop", 32'(sq.rec_valid), 32'd0);
    chk_acc("bp");

    // Flush discards the sample; re-arm respects the period
    wait_ts(10'd20, 200); alloc_pulse(6'd20);
    wait_ts(10'd22, 200);
    sq.flush = 1'b1; @(negedge clk); sq.flush = 1'b0;
    sq.alloc_valid = 1'b1; sq.alloc_idx = 6'd9;
    repeat (3) @(negedge clk);
    sq.alloc_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_rec", 32'(sq.rec_valid), 32'd0);
    start_ts = ts_model();
    alloc_pulse(6'd11);
    wait_ts(10'(start_ts + 10'd3), 200);
    chk("flush_count", 32'(acc_count), 32'(m_cnt));
    exp_q.push_back('{idx: 6'd11, dexec: 10'd3, dend: 10'd3, tout: 1'b0});
    sq.flush = 1'b1;
    retire_pulse(6'd11);
    sq.flush = 1'b0;
    get_record("flush_ret", 0);
    model_accept();
    @(negedge clk);
    chk_acc("flush");

    // Wrap, no exec, en dropped mid-TRACK
    wait_ts(10'd1020, 20000);
    alloc_pulse(6'd63);
    wait_ts(10'd1022, 200); en = 1'b0;
    wait_ts(10'd3, 200);
    exp_q.push_back('{idx: 6'd63, dexec: 10'd7, dend: 10'd7, tout: 1'b0});
    retire_pulse(6'd63);
    get_record("wrap", 0);
    model_accept();
    @(negedge clk);
    chk("wrap_busy_idle", 32'(busy), 32'd0);
    chk_acc("wrap");

    // Reset mid-TRACK
    en = 1'b1;
    wait_ts(10'd6, 200);
    alloc_pulse(6'd2);
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; en = 1'b0;
    m_exec = 0; m_end = 0; m_cnt = 0;
    chk("mrst_ts", 32'(timestamp), 32'd0);
    chk("mrst_valid", 32'(sq.rec_valid), 32'd0);
    chk("mrst_idx", 32'(sq.rec_idx), 32'd0);
    chk("mrst_end", 32'(sq.rec_dur_end), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk_acc("mrst");
    repeat (5) @(negedge clk);
    chk("mrst_silent", 32'(sq.rec_valid), 32'd0);

    // Timeout (period 0 behaves as 1)
    en = 1'b1; period = 8'd0;
    wait_ts(10'd10, 400);
    alloc_pulse(6'd1);
    wait_ts(10'd9, 17000);
    chk("to_not_early", 32'(sq.rec_valid), 32'd0);
`ifdef AVF_SQ_TIMEOUT_EN
    exp_q.push_back('{idx: 6'd1, dexec: 10'd1023, dend: 10'd1023, tout: 1'b1});
    get_record("timeout", 1);
    model_accept();
    @(negedge clk);
    chk_acc("timeout");
`else
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("no_timeout_valid", 32'(sq.rec_valid), 32'd0);
    end
    chk("no_timeout_busy", 32'(busy), 32'd1);
    chk_acc("no_timeout");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
